// File: rtl/fast_ring_thresholder.sv
// fast_ring_thresholder
// Classifies an N-pixel Bresenham ring against its centre pixel.
// Four ce-stallable stages:
//   S1 raw differences, S2 threshold subtract, S3 strict-positive masks and scores,
//   S4 circular arc detection with the masks and scores delayed alongside.
// The datapath is never gated by valid; out_valid tells consumers which outputs are meaningful.

module fast_ring_thresholder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RING_SIZE   = 16,
  parameter int ARC_LEN     = 9,
  parameter int DIFF_WIDTH  = PIXEL_WIDTH + 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              in_valid,
  input  logic [RING_SIZE*PIXEL_WIDTH-1:0]  ring,
  input  logic [PIXEL_WIDTH-1:0]            center,
  input  logic [PIXEL_WIDTH-1:0]            thresh,
  output logic                              out_valid,
  output logic [RING_SIZE*DIFF_WIDTH-1:0]   bright_score,
  output logic [RING_SIZE*DIFF_WIDTH-1:0]   dark_score,
  output logic [RING_SIZE-1:0]              bright_mask,
  output logic [RING_SIZE-1:0]              dark_mask,
  output logic                              bright_corner,
  output logic                              dark_corner,
  output logic                              is_corner
);

  localparam int EXT = DIFF_WIDTH - PIXEL_WIDTH;

  // Zero-extended operands, interpreted as signed DIFF_WIDTH values
  logic signed [DIFF_WIDTH-1:0] ring_ext [RING_SIZE];
  logic signed [DIFF_WIDTH-1:0] center_ext;
  logic signed [DIFF_WIDTH-1:0] thresh_ext;

  // S1 registers
  logic                         valid_s1;
  logic signed [DIFF_WIDTH-1:0] thresh_s1;
  logic signed [DIFF_WIDTH-1:0] raw_bright_s1 [RING_SIZE];
  logic signed [DIFF_WIDTH-1:0] raw_dark_s1   [RING_SIZE];

  // S2 registers
  logic                         valid_s2;
  logic signed [DIFF_WIDTH-1:0] diff_bright_s2 [RING_SIZE];
  logic signed [DIFF_WIDTH-1:0] diff_dark_s2   [RING_SIZE];

  // S3 registers
  logic                            valid_s3;
  logic [RING_SIZE-1:0]            mask_bright_s3;
  logic [RING_SIZE-1:0]            mask_dark_s3;
  logic [RING_SIZE*DIFF_WIDTH-1:0] score_bright_s3;
  logic [RING_SIZE*DIFF_WIDTH-1:0] score_dark_s3;

  // True when the mask holds ARC_LEN consecutive ones, allowing wrap from N-1 to 0.
  // Doubling the mask turns every circular window into a plain slice.
  function automatic logic arc_hit(input logic [RING_SIZE-1:0] m);
    logic [2*RING_SIZE-1:0] dbl;
    logic                   hit;
    dbl = {m, m};
    hit = 1'b0;
    for (int s = 0; s < RING_SIZE; s++) begin
      if (&dbl[s +: ARC_LEN]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Operand widening; the two extra bits keep every difference in range
  always_comb begin
    center_ext = $signed({{EXT{1'b0}}, center});
    thresh_ext = $signed({{EXT{1'b0}}, thresh});
    for (int i = 0; i < RING_SIZE; i++) begin
      ring_ext[i] = $signed({{EXT{1'b0}}, ring[i*PIXEL_WIDTH +: PIXEL_WIDTH]});
    end
  end

  // S1: raw bright/dark differences, threshold captured with its own sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s1  <= 1'b0;
      thresh_s1 <= '0;
      for (int i = 0; i < RING_SIZE; i++) begin
        raw_bright_s1[i] <= '0;
        raw_dark_s1[i]   <= '0;
      end
    end else if (ce) begin
      valid_s1  <= in_valid;
      thresh_s1 <= thresh_ext;
      for (int i = 0; i < RING_SIZE; i++) begin
        raw_bright_s1[i] <= ring_ext[i] - center_ext;
        raw_dark_s1[i]   <= center_ext - ring_ext[i];
      end
    end
  end

  // S2: subtract the sample's own threshold from both polarities
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s2 <= 1'b0;
      for (int i = 0; i < RING_SIZE; i++) begin
        diff_bright_s2[i] <= '0;
        diff_dark_s2[i]   <= '0;
      end
    end else if (ce) begin
      valid_s2 <= valid_s1;
      for (int i = 0; i < RING_SIZE; i++) begin
        diff_bright_s2[i] <= raw_bright_s1[i] - thresh_s1;
        diff_dark_s2[i]   <= raw_dark_s1[i] - thresh_s1;
      end
    end
  end

  // S3: strictly positive differences set the mask and pass through as scores
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s3        <= 1'b0;
      mask_bright_s3  <= '0;
      mask_dark_s3    <= '0;
      score_bright_s3 <= '0;
      score_dark_s3   <= '0;
    end else if (ce) begin
      valid_s3 <= valid_s2;
      for (int i = 0; i < RING_SIZE; i++) begin
        if (diff_bright_s2[i] > 0) begin
          mask_bright_s3[i]                          <= 1'b1;
          score_bright_s3[i*DIFF_WIDTH +: DIFF_WIDTH] <= diff_bright_s2[i];
        end else begin
          mask_bright_s3[i]                          <= 1'b0;
          score_bright_s3[i*DIFF_WIDTH +: DIFF_WIDTH] <= '0;
        end
        if (diff_dark_s2[i] > 0) begin
          mask_dark_s3[i]                          <= 1'b1;
          score_dark_s3[i*DIFF_WIDTH +: DIFF_WIDTH] <= diff_dark_s2[i];
        end else begin
          mask_dark_s3[i]                          <= 1'b0;
          score_dark_s3[i*DIFF_WIDTH +: DIFF_WIDTH] <= '0;
        end
      end
    end
  end

  // S4: arc decisions, with masks and scores delayed to line up with them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      bright_mask   <= '0;
      dark_mask     <= '0;
      bright_score  <= '0;
      dark_score    <= '0;
      bright_corner <= 1'b0;
      dark_corner   <= 1'b0;
      is_corner     <= 1'b0;
    end else if (ce) begin
      out_valid     <= valid_s3;
      bright_mask   <= mask_bright_s3;
      dark_mask     <= mask_dark_s3;
      bright_score  <= score_bright_s3;
      dark_score    <= score_dark_s3;
      bright_corner <= arc_hit(mask_bright_s3);
      dark_corner   <= arc_hit(mask_dark_s3);
      is_corner     <= arc_hit(mask_bright_s3) | arc_hit(mask_dark_s3);
    end
  end

endmodule

// File: tb/tb_fast_ring_thresholder.sv
// Directed bench for fast_ring_thresholder with default parameters (N=16, 8-bit pixels).
module tb_fast_ring_thresholder;

  localparam int PW = 8;
  localparam int N  = 16;
  localparam int DW = PW + 2;
  localparam int RW = N * PW;
  localparam int SW = N * DW;

  typedef struct {
    logic [RW-1:0] ring;
    logic [PW-1:0] center;
    logic [PW-1:0] thresh;
    logic [N-1:0]  bm;
    logic [N-1:0]  dm;
    logic          bc;
    logic          dc;
    logic [SW-1:0] bs;
    logic [SW-1:0] ds;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          in_valid;
  logic [RW-1:0] ring;
  logic [PW-1:0] center;
  logic [PW-1:0] thresh;
  logic          out_valid;
  logic [SW-1:0] bright_score;
  logic [SW-1:0] dark_score;
  logic [N-1:0]  bright_mask;
  logic [N-1:0]  dark_mask;
  logic          bright_corner;
  logic          dark_corner;
  logic          is_corner;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [9];
  vec_t seq  [3];
  vec_t zero_v;

  fast_ring_thresholder #(
    .PIXEL_WIDTH(PW), .RING_SIZE(N), .ARC_LEN(9), .DIFF_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .ring(ring), .center(center), .thresh(thresh),
    .out_valid(out_valid), .bright_score(bright_score), .dark_score(dark_score),
    .bright_mask(bright_mask), .dark_mask(dark_mask),
    .bright_corner(bright_corner), .dark_corner(dark_corner), .is_corner(is_corner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ring with value hi where mask bit set, lo elsewhere
  function automatic logic [RW-1:0] mk_ring(input logic [N-1:0] m, input logic [PW-1:0] hi,
                                            input logic [PW-1:0] lo);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = m[i] ? hi : lo;
    return r;
  endfunction

  // packed scores: v where mask bit set, 0 elsewhere
  function automatic logic [SW-1:0] sel(input logic [N-1:0] m, input logic [DW-1:0] v);
    logic [SW-1:0] s;
    for (int i = 0; i < N; i++) s[i*DW +: DW] = m[i] ? v : '0;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t v, input logic ev, input string tag);
    chk({tag, "/out_valid"},     SW'(out_valid),     SW'(ev));
    chk({tag, "/bright_mask"},   SW'(bright_mask),   SW'(v.bm));
    chk({tag, "/dark_mask"},     SW'(dark_mask),     SW'(v.dm));
    chk({tag, "/bright_corner"}, SW'(bright_corner), SW'(v.bc));
    chk({tag, "/dark_corner"},   SW'(dark_corner),   SW'(v.dc));
    chk({tag, "/is_corner"},     SW'(is_corner),     SW'(v.bc | v.dc));
    chk({tag, "/bright_score"},  bright_score,       v.bs);
    chk({tag, "/dark_score"},    dark_score,         v.ds);
  endtask

  task automatic drive(input vec_t v);
    ring     = v.ring;
    center   = v.center;
    thresh   = v.thresh;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single isolated sample: out_valid must stay low for 3 edges and rise on the 4th
  task automatic send(input vec_t v, input string tag);
    drive(v);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      if (c < 4) chk({tag, "/latency"}, SW'(out_valid), SW'(1'b0));
      else       check_outs(v, 1'b1, tag);
    end
  endtask

  initial begin
    zero_v = '{'0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0};

    vecs[0] = '{mk_ring(16'hFFFF, 8'd120, 8'd0),   8'd100, 8'd10,  16'hFFFF, 16'h0000, 1'b1, 1'b0,
                sel(16'hFFFF, 10'd10), '0};
    vecs[1] = '{mk_ring(16'hF01F, 8'd150, 8'd100), 8'd100, 8'd10,  16'hF01F, 16'h0000, 1'b1, 1'b0,
                sel(16'hF01F, 10'd40), '0};
    vecs[2] = '{mk_ring(16'hF00F, 8'd150, 8'd100), 8'd100, 8'd10,  16'hF00F, 16'h0000, 1'b0, 1'b0,
                sel(16'hF00F, 10'd40), '0};
    vecs[3] = '{mk_ring(16'hFFFF, 8'd110, 8'd0),   8'd100, 8'd10,  16'h0000, 16'h0000, 1'b0, 1'b0,
                '0, '0};
    vecs[4] = '{mk_ring(16'hFFFF, 8'd0, 8'd0),     8'd200, 8'd255, 16'h0000, 16'h0000, 1'b0, 1'b0,
                '0, '0};
    vecs[5] = '{mk_ring(16'hFFFF, 8'd0, 8'd0),     8'd200, 8'd199, 16'h0000, 16'hFFFF, 1'b0, 1'b1,
                '0, sel(16'hFFFF, 10'd1)};
    vecs[6] = '{mk_ring(16'h00FF, 8'd101, 8'd99),  8'd100, 8'd0,   16'h00FF, 16'hFF00, 1'b0, 1'b0,
                sel(16'h00FF, 10'd1), sel(16'hFF00, 10'd1)};
    vecs[7] = '{mk_ring(16'h01FF, 8'd90, 8'd100),  8'd100, 8'd5,   16'h0000, 16'h01FF, 1'b0, 1'b1,
                '0, sel(16'h01FF, 10'd5)};
    vecs[8] = '{mk_ring(16'hFFFF, 8'd255, 8'd0),   8'd0,   8'd0,   16'hFFFF, 16'h0000, 1'b1, 1'b0,
                sel(16'hFFFF, 10'd255), '0};

    seq[0] = '{mk_ring(16'hFFFF, 8'd130, 8'd0), 8'd100, 8'd10, 16'hFFFF, 16'h0000, 1'b1, 1'b0,
               sel(16'hFFFF, 10'd20), '0};
    seq[1] = '{mk_ring(16'hFFFF, 8'd130, 8'd0), 8'd100, 8'd50, 16'h0000, 16'h0000, 1'b0, 1'b0,
               '0, '0};
    seq[2] = '{mk_ring(16'hFFFF, 8'd130, 8'd0), 8'd100, 8'd0,  16'hFFFF, 16'h0000, 1'b1, 1'b0,
               sel(16'hFFFF, 10'd30), '0};

    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; ring = '0; center = '0; thresh = '0;
    tick(); tick();
    check_outs(zero_v, 1'b0, "reset");
    rst = 1'b0;
    tick();

    // table-driven isolated samples
    for (int k = 0; k < 9; k++) send(vecs[k], $sformatf("vec%0d", k));

    // back-to-back thresholds 10, 50, 0
    for (int k = 0; k < 3; k++) begin
      drive(seq[k]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_outs(seq[k], 1'b1, $sformatf("stream%0d", k));
      tick();
    end
    chk("stream/tail_valid", SW'(out_valid), SW'(1'b0));

    // ce stall with the stream in flight; junk presented while stalled must be ignored
    for (int k = 0; k < 3; k++) begin
      drive(seq[k]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_outs(seq[0], 1'b1, "stall/pre");
    ce = 1'b0;
    drive(vecs[6]);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outs(seq[0], 1'b1, $sformatf("stall/hold%0d", c));
    end
    ce = 1'b1;
    in_valid = 1'b0;
    tick();
    check_outs(seq[1], 1'b1, "stall/resume1");
    tick();
    check_outs(seq[2], 1'b1, "stall/resume2");
    tick();
    chk("stall/tail_valid", SW'(out_valid), SW'(1'b0));

    // asynchronous reset mid-cycle with samples in flight
    for (int k = 0; k < 4; k++) begin
      drive(vecs[0]);
      tick();
    end
    in_valid = 1'b0;
    check_outs(vecs[0], 1'b1, "rst/pre");
    #2 rst = 1'b1;
    #1 check_outs(zero_v, 1'b0, "rst/immediate");
    tick();
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rst/flushed%0d", c), SW'(out_valid), SW'(1'b0));
    end
    send(vecs[1], "rst/after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
